// File: rtl/pipe_if_pkg.sv
// Shared definitions for the instruction-fetch stage: fetch FSM states,
// next-PC select encodings and the bubble instruction word.
package pipe_if_pkg;
  typedef enum logic [1:0] {FETCH, HOLD, DROP} fstate_t;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_J   = 2'b11;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;  // sll $0,$0,0
endpackage

// File: rtl/pipe_fetch_if.sv
// Instruction-memory request/response handshake seen by the fetch stage.
interface pipe_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/pipe_ifid_reg.sv
// IF/ID pipeline register: holds by default, loads either a real word or a
// bubble (bubble keeps the previous dpc4).
module pipe_ifid_reg #(
  parameter logic [31:0] NOP_INST = pipe_if_pkg::NOP_INST
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] ld_pc4,
  input  logic [31:0] ld_inst,
  output logic [31:0] dpc4,
  output logic [31:0] inst,
  output logic        dvalid
);
  always_ff @(posedge clock) begin
    if (reset) begin
      dpc4   <= '0;
      inst   <= NOP_INST;
      dvalid <= 1'b0;
    end else if (load) begin
      if (bubble) begin
        inst   <= NOP_INST;
        dvalid <= 1'b0;
      end else begin
        dpc4   <= ld_pc4;
        inst   <= ld_inst;
        dvalid <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/pipe_fetch.sv
// Instruction-fetch stage: PC, next-PC select, imem handshake FSM and the
// IF/ID register. Stale fetches after a redirect are retired in DROP.
module pipe_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = pipe_if_pkg::NOP_INST
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] rpc,
  input  logic        wpcir,
  input  logic        djflush,
  pipe_fetch_if.master imem,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] inst,
  output logic        dvalid
);
  import pipe_if_pkg::*;

  fstate_t     state, state_n;
  logic [31:0] pc_n, tgt_q, tgt_n, hold_q, hold_n;
  logic [31:0] pc4, tgt;
  logic        redirect, ld, bub;
  logic [31:0] ld_inst;

  assign pc4      = pc + 32'd4;
  assign redirect = wpcir & (pcsource != PC_SEQ);

  always_comb begin
    tgt = pc4;
    case (pcsource)
      PC_BR:   tgt = bpc & ~32'h3;
      PC_JR:   tgt = rpc & ~32'h3;
      PC_J:    tgt = jpc & ~32'h3;
      default: tgt = pc4;
    endcase
  end

  // In DROP pc still holds the stale address, so imem_addr stays stable.
  assign imem.imem_req  = ~reset & (state != HOLD);
  assign imem.imem_addr = pc;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    tgt_n   = tgt_q;
    hold_n  = hold_q;
    ld      = 1'b0;
    bub     = 1'b0;
    ld_inst = imem.imem_rdata;
    case (state)
      FETCH: begin
        if (redirect) begin
          ld  = 1'b1;
          bub = 1'b1;
          if (imem.imem_ready) pc_n = tgt;
          else begin
            tgt_n   = tgt;
            state_n = DROP;
          end
        end else if (wpcir) begin
          ld = 1'b1;
          if (imem.imem_ready) begin
            bub  = djflush;
            pc_n = pc4;
          end else bub = 1'b1;
        end else if (imem.imem_ready) begin
          hold_n  = imem.imem_rdata;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          ld      = 1'b1;
          bub     = 1'b1;
          pc_n    = tgt;
          state_n = FETCH;
        end else if (wpcir) begin
          ld      = 1'b1;
          bub     = djflush;
          ld_inst = hold_q;
          pc_n    = pc4;
          state_n = FETCH;
        end
      end
      DROP: begin
        if (wpcir) begin
          ld  = 1'b1;
          bub = 1'b1;
        end
        if (redirect) tgt_n = tgt;
        if (imem.imem_ready) begin
          pc_n    = redirect ? tgt : tgt_q;
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      tgt_q  <= '0;
      hold_q <= '0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      tgt_q  <= tgt_n;
      hold_q <= hold_n;
    end
  end

  pipe_ifid_reg #(.NOP_INST(NOP_INST)) u_ifid (
    .clock   (clock),
    .reset   (reset),
    .load    (ld),
    .bubble  (bub),
    .ld_pc4  (pc4),
    .ld_inst (ld_inst),
    .dpc4    (dpc4),
    .inst    (inst),
    .dvalid  (dvalid)
  );
endmodule

// File: tb/tb_pipe_fetch.sv
// Fetch-stage bench: directed steps then random traffic, each cycle checked
// against a transaction-level model (buffered-word queue, stale-fetch flag).
module tb_pipe_fetch;
  import pipe_if_pkg::*;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  pcsource;
  logic [31:0] bpc, jpc, rpc;
  logic        wpcir, djflush;
  logic [31:0] pc, dpc4, inst;
  logic        dvalid;

  pipe_fetch_if imem();

  pipe_fetch dut (
    .clock(clock), .reset(reset), .pcsource(pcsource),
    .bpc(bpc), .jpc(jpc), .rpc(rpc), .wpcir(wpcir), .djflush(djflush),
    .imem(imem), .pc(pc), .dpc4(dpc4), .inst(inst), .dvalid(dvalid)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // reference model
  logic [31:0] m_pc, m_dpc4, m_inst, m_tgt;
  logic        m_dvalid, m_drop;
  logic [31:0] m_buf[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bubble_m();
    m_inst   = NOP_INST;
    m_dvalid = 1'b0;
  endtask

  task automatic deliver_m(input logic [31:0] w, input bit dj);
    if (dj) bubble_m();
    else begin
      m_dpc4   = m_pc + 32'd4;
      m_inst   = w;
      m_dvalid = 1'b1;
    end
  endtask

  task automatic model(input bit r, input logic [1:0] ps, input logic [31:0] b, j, rr,
                       input bit w, dj, rdy, input logic [31:0] rd);
    logic [31:0] t;
    bit          redir;
    redir = w && (ps != PC_SEQ);
    t = (ps == PC_BR) ? b : (ps == PC_JR) ? rr : j;
    t = t & ~32'h3;
    if (r) begin
      m_pc = 32'h0; m_dpc4 = 32'h0; m_inst = NOP_INST; m_dvalid = 1'b0;
      m_buf.delete(); m_drop = 1'b0;
    end else if (m_buf.size() > 0) begin
      if (redir) begin
        bubble_m(); m_pc = t; m_buf.delete();
      end else if (w) begin
        deliver_m(m_buf.pop_front(), dj); m_pc = m_pc + 32'd4;
      end
    end else if (m_drop) begin
      if (w) bubble_m();
      if (redir) m_tgt = t;
      if (rdy) begin m_pc = m_tgt; m_drop = 1'b0; end
    end else if (redir) begin
      bubble_m();
      if (rdy) m_pc = t;
      else begin m_drop = 1'b1; m_tgt = t; end
    end else if (w) begin
      if (rdy) begin deliver_m(rd, dj); m_pc = m_pc + 32'd4; end
      else bubble_m();
    end else if (rdy) m_buf.push_back(rd);
  endtask

  task automatic check_all(input bit r);
    logic exp_req;
    exp_req = !r && (m_buf.size() == 0);
    check("pc", pc, m_pc);
    check("imem_req", {31'b0, imem.imem_req}, {31'b0, exp_req});
    if (exp_req) check("imem_addr", imem.imem_addr, m_pc);
    check("dvalid", {31'b0, dvalid}, {31'b0, m_dvalid});
    check("dpc4", dpc4, m_dpc4);
    check("inst", inst, m_inst);
  endtask

  task automatic cyc(input bit r, input logic [1:0] ps, input logic [31:0] b, j, rr,
                     input bit w, dj, rdy);
    logic [31:0] rd;
    rd = m_pc ^ K;
    reset = r; pcsource = ps; bpc = b; jpc = j; rpc = rr;
    wpcir = w; djflush = dj; imem.imem_ready = rdy; imem.imem_rdata = rd;
    model(r, ps, b, j, rr, w, dj, rdy, rd);
    @(negedge clock);
    check_all(r);
  endtask

  initial begin
    m_pc = '0; m_dpc4 = '0; m_inst = NOP_INST; m_dvalid = 1'b0; m_drop = 1'b0; m_tgt = '0;

    // reset state
    cyc(1, PC_SEQ, 0, 0, 0, 1, 0, 1);
    cyc(1, PC_SEQ, 0, 0, 0, 1, 0, 1);
    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'b0, imem.imem_req}, 32'h0);

    // zero-wait streaming; first real word carries dpc4=4
    cyc(0, PC_SEQ, 0, 0, 0, 1, 0, 1);
    check("first_dpc4", dpc4, 32'h4);
    check("first_inst", inst, 32'h0 ^ K);
    cyc(0, PC_SEQ, 0, 0, 0, 1, 0, 1);

    // stall 3 cycles at pc=8 then release
    repeat (3) cyc(0, PC_SEQ, 0, 0, 0, 0, 0, 1);
    check("hold_pc", pc, 32'h8);
    check("hold_req", {31'b0, imem.imem_req}, 32'h0);
    cyc(0, PC_SEQ, 0, 0, 0, 1, 0, 1);
    check("hold_inst", inst, 32'h8 ^ K);
    check("hold_dpc4", dpc4, 32'hC);
    cyc(0, PC_SEQ, 0, 0, 0, 1, 0, 1);

    // taken branch at pc=0x10, zero-wait
    cyc(0, PC_BR, 32'h40, 0, 0, 1, 0, 1);
    check("br_pc", pc, 32'h40);
    cyc(0, PC_SEQ, 0, 0, 0, 1, 0, 1);
    check("br_inst", inst, 32'h40 ^ K);
    check("br_dpc4", dpc4, 32'h44);

    // branch at pc=0x44 with 3-cycle memory
    cyc(0, PC_BR, 32'h40, 0, 0, 1, 0, 0);
    cyc(0, PC_SEQ, 0, 0, 0, 1, 0, 0);
    cyc(0, PC_SEQ, 0, 0, 0, 1, 0, 1);
    check("drop_pc", pc, 32'h40);
    check("drop_dvalid", {31'b0, dvalid}, 32'h0);

    // djflush at pc=0x20
    cyc(0, PC_J, 0, 32'h20, 0, 1, 0, 1);
    cyc(0, PC_SEQ, 0, 0, 0, 1, 1, 1);
    check("flush_pc", pc, 32'h24);
    check("flush_dvalid", {31'b0, dvalid}, 32'h0);

    // reset in DROP and in HOLD, then masked jr target
    cyc(0, PC_BR, 32'h80, 0, 0, 1, 0, 0);
    cyc(1, PC_SEQ, 0, 0, 0, 1, 0, 1);
    check("rst_drop_pc", pc, 32'h0);
    cyc(0, PC_SEQ, 0, 0, 0, 0, 0, 1);
    cyc(1, PC_SEQ, 0, 0, 0, 1, 0, 1);
    cyc(0, PC_JR, 0, 0, 32'h43, 1, 0, 1);
    check("jr_pc", pc, 32'h40);

    // pc+4 wrap
    cyc(0, PC_J, 0, 32'hFFFF_FFFC, 0, 1, 0, 1);
    cyc(0, PC_SEQ, 0, 0, 0, 1, 0, 1);
    check("wrap_pc", pc, 32'h0);
    check("wrap_dpc4", dpc4, 32'h0);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      bit r, w, dj, rdy;
      logic [1:0] ps;
      r   = ($urandom_range(0, 49) == 0);
      ps  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : PC_SEQ;
      w   = ($urandom_range(0, 3) != 0);
      dj  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      cyc(r, ps, $urandom, $urandom, $urandom, w, dj, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipe_fetch.md
Name: pipe_fetch

Overview:
- Instruction-fetch stage of the 5-stage pipelined MIPS core.
- Owns the PC and the instruction-memory request handshake, and drives the IF/ID pipeline register.
- Feeds dpc4/inst to the decode stage and consumes that stage's redirect and stall controls: pcsource, bpc, jpc, rpc, wpcir, djflush.
- Tolerates multi-cycle instruction memory and discards in-flight fetches made stale by a taken branch or jump.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0)

Ports:
clock  in  1  sole clock; all state updates on rising edge
reset  in  1  synchronous, active-high
pcsource  in  2  next-PC select from decode: 00 pc+4, 01 bpc, 10 rpc, 11 jpc
bpc  in  32  branch target
jpc  in  32  jump target
rpc  in  32  register jump target (jr)
wpcir  in  1  1 = decode accepts a new IF/ID word; 0 = stall (hold PC and IF/ID)
djflush  in  1  forces a bubble into IF/ID on the next accepted cycle
imem_req  out  1  instruction fetch request
imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ready=0
imem_ready  in  1  memory returns imem_rdata this cycle; may be high on the first request cycle
imem_rdata  in  32  fetched word
pc  out  32  current fetch PC
dpc4  out  32  IF/ID: PC+4 of the held instruction
inst  out  32  IF/ID: instruction
dvalid  out  1  IF/ID: 1 = real instruction, 0 = bubble

Behaviour:
- Reset (synchronous, active-high):
  - pc=RESET_PC, dpc4=0, inst=NOP_INST, dvalid=0, state=FETCH.
  - imem_req=0 while reset=1.
  - Reset overrides every other event, including mid-fetch or in HOLD/DROP; any returning word is ignored.
- Redirect event R = wpcir & (pcsource!=00). Target T = bpc/rpc/jpc per pcsource. T[1:0] is forced to 00 when loaded into pc.
- Bubble load: dpc4 unchanged, inst=NOP_INST, dvalid=0.
- State FETCH (imem_req=1, imem_addr=pc):
  - R & ready: pc<=T; IF/ID<=bubble; stay FETCH.
  - R & ~ready: tgt_q<=T; IF/ID<=bubble; go DROP.
  - ~R & wpcir & ready: IF/ID<={pc+4, imem_rdata, 1}, or a bubble if djflush; pc<=pc+4.
  - ~R & wpcir & ~ready: IF/ID<=bubble; pc held.
  - ~wpcir & ready: hold_q<=imem_rdata; go HOLD; IF/ID unchanged.
  - ~wpcir & ~ready: nothing changes.
- State HOLD (imem_req=0, word buffered):
  - R: pc<=T; hold_q dropped; IF/ID<=bubble; go FETCH.
  - wpcir: IF/ID<={pc+4, hold_q, 1}, or a bubble if djflush; pc<=pc+4; go FETCH.
  - else: stay.
- State DROP (imem_req=1, imem_addr=old pc; waiting to retire a stale fetch):
  - wpcir: IF/ID<=bubble.
  - A further R while in DROP overwrites tgt_q with the new T.
  - ready: data discarded; pc<=tgt_q, or the new T if R occurs in the same cycle; go FETCH.
- Throughput and latency:
  - Zero-wait memory with wpcir=1 sustains one instruction per cycle.
  - An instruction fetched in cycle n appears on inst in cycle n+1.
- Taken-branch penalty: exactly one bubble with zero-wait memory. The instruction fetched in the redirect cycle is never delivered.
- pc+4 wraps modulo 2^32 (FFFF_FFFC -> 0000_0000, dpc4=0).

Decomposition:
- Shared package pipe_if_pkg:
  - fetch-state enum {FETCH, HOLD, DROP}
  - pcsource encodings PC_SEQ=00, PC_BR=01, PC_JR=10, PC_J=11
  - NOP_INST constant
- One sub-module pipe_ifid_reg: IF/ID register with load, bubble and hold controls.
- Next-PC mux and FSM stay in pipe_fetch.

Test Plan:
1. Reset then zero-wait memory (ready=1, rdata=addr^A5A5_0000), wpcir=1 -> imem_addr 0,4,8...; inst/dpc4 lag one cycle; first dvalid=1 carries dpc4=4.
2. Hold wpcir=0 for 3 cycles with ready=1 at pc=8 -> state HOLD, imem_req=0, pc stays 8, IF/ID unchanged; on release inst=word@8, dpc4=C.
3. pcsource=01, bpc=0x40, wpcir=1, ready=1 at pc=0x10 -> next cycle pc=0x40, dvalid=0; word@0x40 delivered the following cycle with dpc4=0x44.
4. Same redirect with ready=0 for 2 cycles (memory 3-cycle latency) -> imem_addr holds 0x10 until ready, data discarded, then imem_addr=0x40; no dvalid=1 for word@0x10.
5. djflush=1, pcsource=00, ready=1 at pc=0x20 -> IF/ID bubble, pc=0x24.
6. reset=1 asserted in DROP and in HOLD -> next cycle pc=RESET_PC, dvalid=0, imem_req=0; stale ready ignored; pcsource=10, rpc=0x43 -> pc=0x40.
